serial_rx: RTL
==============

# serial_rx

Serial-to-parallel receiver that deserializes an asynchronous 8N1 bit stream into bytes. It presents each byte on `dout` together with a one-cycle `load` strobe, so it drives the 8-bit holding register's `din`/`load` inputs directly. It sits at the input edge of the datapath, between the external serial line and the byte register.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be even and ≥ 4.
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `rxd`  in  1: serial line, idle high, asynchronous to `clk`.
- `dout`  out  DATA_WIDTH: last correctly framed byte; held until the next good frame.
- `load`  out  1: one-cycle strobe; `dout` is valid in the same cycle.
- `frame_err`  out  1: one-cycle strobe on a bad stop bit.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (output `rxd_s`). Both flops reset to 1.
- Bit counter `cnt` runs 0..CLKS_PER_BIT-1. Bit index `idx` runs 0..DATA_WIDTH-1. Shift register `sh`. H = CLKS_PER_BIT/2.
- **IDLE:** when `rxd_s` == 0, go to START with `cnt` = 0.
- **START:** at `cnt` == H-1, sample `rxd_s`.
  - If 1, this is a false start: return to IDLE with no strobe.
  - If 0, go to DATA with `cnt` = 0 and `idx` = 0. This aligns all later samples to mid-bit.
- **DATA:** at `cnt` == CLKS_PER_BIT-1, sample `rxd_s` and shift it in LSB-first: `sh` <= {rxd_s, sh[W-1:1]}. Then `idx`++ and `cnt` = 0.
  - After bit DATA_WIDTH-1 is sampled, go to STOP.
- **STOP:** at `cnt` == CLKS_PER_BIT-1, sample `rxd_s`.
  - If 1: `dout` <= `sh`, pulse `load`, go to IDLE.
  - If 0: pulse `frame_err`, leave `dout` unchanged, go to BREAK.
- **BREAK:** wait until `rxd_s` == 1, then go to IDLE. A line held low must not produce repeated frames.
- `load` and `frame_err` are registered, mutually exclusive, and never high for more than one cycle.
- Reset state:
  - state IDLE;
  - `dout` = 0, `load` = 0, `frame_err` = 0, `busy` = 0;
  - `cnt`, `idx`, `sh` = 0;
  - synchronizer flops = 1.
- Reset asserted mid-frame abandons the frame immediately. No strobe is issued, either during reset or after it is released.

## Timing
- Let E0 be the first `clk` edge at which `rxd` is sampled 0.
  - The START transition occurs at edge E0+2.
  - `load` or `frame_err` is high in the cycle following edge E0+2+H+9·CLKS_PER_BIT.
  - For CLKS_PER_BIT = 16, this is edge E0+154.
- The receiver returns to IDLE at the mid-stop sample. A start edge arriving H cycles later (back-to-back frames) is accepted.
- A low glitch shorter than H cycles, measured at `rxd_s`, is rejected as a false start.
- `busy` rises at edge E0+2 and falls on the same edge that raises `load`/`frame_err`. After a frame error, `busy` stays high until BREAK exits.
- Throughput: one byte per 10·CLKS_PER_BIT cycles at most.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum `rx_state_t` {IDLE, START, DATA, STOP, BREAK};
  - the default constants `CLKS_PER_BIT_DEF` = 16 and `DATA_WIDTH_DEF` = 8.
- The natural sub-module is `sync2`, a 2-flop synchronizer with parameterized reset value (1 here). It is instantiated once.
- Everything else (counters, FSM, shift register, output registers) stays in `serial_rx`.

## Test plan
All scenarios use CLKS_PER_BIT = 16.

- **Single byte:** after reset, send frame 0xA5 with stop = 1 → exactly one `load` pulse at E0+154, `dout` = 0xA5, `frame_err` stays 0.
- **Back-to-back frames:** send 0x0A then 0x03 with no idle gap → two `load` pulses exactly 160 cycles apart; `dout` = 0x0A, then 0x03.
- **False start:** drive `rxd` low for 4 cycles, then high → no strobe; `busy` high briefly, then 0; next frame 0x55 is received correctly.
- **Framing error:** with `dout` = 0x55, send 0x3C with stop = 0, then hold `rxd` low for 50 cycles → one `frame_err` pulse, no `load`, `dout` stays 0x55, `busy` stays high until the line returns high. A following 0xFF frame is received.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x96 → `dout` = 0 and `busy` = 0 immediately; release `reset` with the line high, send 0x00 → one `load`, `dout` = 0x00.
- **Line stuck high:** hold `rxd` high for 1000 cycles → `busy`, `load`, and `frame_err` all stay 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: receiver FSM states and default frame geometry.
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_WIDTH_DEF   = 8;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer that brings an asynchronous level into the clk domain.
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: non-blocking assignments make each flop capture its pre-edge input; blocking would collapse the chain to one stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: deserializes rxd LSB-first and presents each good byte with a one-cycle load strobe.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  load,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             state, state_next;
    logic                  rxd_s;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] sh;
    logic                  cnt_clr, shift_en, load_next, err_next;
    logic                  half_hit, full_hit, idx_last;

    sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign half_hit = (cnt == CW'(HALF - 1));
    assign full_hit = (cnt == CW'(CLKS_PER_BIT - 1));
    assign idx_last = (idx == IW'(DATA_WIDTH - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b1;
        shift_en   = 1'b0;
        load_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE:  if (!rxd_s) state_next = START;
            START: begin
                // Re-checking the line at mid start bit rejects glitches and centres later samples.
                cnt_clr = half_hit;
                if (half_hit) state_next = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                cnt_clr  = full_hit;
                shift_en = full_hit;
                if (full_hit && idx_last) state_next = STOP;
            end
            STOP: begin
                cnt_clr = full_hit;
                if (full_hit) begin
                    load_next  = rxd_s;
                    err_next   = !rxd_s;
                    state_next = rxd_s ? IDLE : BREAK;
                end
            end
            // A line held low must return high before another start bit can be seen.
            BREAK: if (rxd_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Async reset clears the whole datapath, so a frame in flight is dropped with no strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            dout      <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state != DATA) idx <= '0;
            else if (shift_en) idx <= idx + IW'(1);
            if (shift_en)  sh   <= {rxd_s, sh[DATA_WIDTH-1:1]};
            if (load_next) dout <= sh;
            load      <= load_next;
            frame_err <= err_next;
        end
    end
endmodule
